// File: rtl/ccd_cds_sampler.sv
// Correlated-double-sampling controller: watches CCD phase lines, requests a reset
// and a signal conversion per pixel, and streams the clamped difference.
module ccd_cds_sampler #(
  parameter int ADC_W       = 12,
  parameter int PIXELS      = 2051,
  parameter int SETTLE_CYC  = 8,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             phi_p,
  input  logic             phi_r,
  input  logic             phi_l1,
  output logic             adc_start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             frame_active,
  input  logic             err_clr,
  output logic             overflow,
  output logic             seq_err,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(PIXELS + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SET_R  = 3'd2;
  localparam logic [2:0] S_SET_S  = 3'd3;
  localparam logic [2:0] S_CONV_R = 3'd4;
  localparam logic [2:0] S_CONV_S = 3'd5;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(PIXELS);
  localparam logic [7:0]       SETTLE_END = 8'(SETTLE_CYC - 1);
  localparam logic [9:0]       TMO_END    = 10'(ADC_TIMEOUT - 1);

  // Phase bits ordered {phi_p, phi_r, phi_l1}.
  logic [2:0]       ph_q, ph_d, ph_prev_q, ph_prev_d;
  logic [2:0]       state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [9:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             have_ref_q, have_ref_d;
  logic [ADC_W-1:0] ref_q, ref_d;
  logic             adc_start_q, adc_start_d;
  logic             pix_valid_q, pix_valid_d;
  logic [ADC_W-1:0] pix_data_q, pix_data_d;
  logic             pix_last_q, pix_last_d;
  logic             frame_active_q, frame_active_d;
  logic             overflow_q, overflow_d;
  logic             seq_err_q, seq_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic             fs, re, se, done, push, accept;
  logic             ovf_set, seq_set, tmo_set;
  logic signed [ADC_W:0] diff;
  logic [ADC_W-1:0] pix_calc;

  // Stream handshake: a pixel transfers on any rising clk edge where pix_valid and
  // pix_ready are both high; pix_data/pix_last hold steady until that transfer.
  always_comb begin
    ph_d      = {phi_p, phi_r, phi_l1};
    ph_prev_d = ph_q;
    fs        = ph_prev_q[2] & ~ph_q[2];
    re        = ph_prev_q[1] & ~ph_q[1];
    se        = ~ph_prev_q[0] & ph_q[0];
    done      = (pix_cnt_q == FULL_CNT);
    accept    = pix_valid_q & pix_ready;

    diff      = $signed({1'b0, ref_q}) - $signed({1'b0, adc_data});
    pix_calc  = diff[ADC_W] ? '0 : diff[ADC_W-1:0];

    state_d        = state_q;
    settle_d       = settle_q;
    tmo_d          = tmo_q;
    pix_cnt_d      = pix_cnt_q;
    have_ref_d     = have_ref_q;
    ref_d          = ref_q;
    adc_start_d    = 1'b0;
    pix_valid_d    = pix_valid_q & ~pix_ready;
    pix_data_d     = pix_data_q;
    pix_last_d     = accept ? 1'b0 : pix_last_q;
    frame_active_d = (accept && pix_last_q) ? 1'b0 : frame_active_q;
    push           = 1'b0;
    ovf_set        = 1'b0;
    seq_set        = 1'b0;
    tmo_set        = 1'b0;

    if (!enable) begin
      state_d    = S_IDLE;
      have_ref_d = 1'b0;
    end else if (fs) begin
      state_d        = S_WAIT;
      pix_cnt_d      = '0;
      have_ref_d     = 1'b0;
      frame_active_d = 1'b1;
      settle_d       = '0;
      tmo_d          = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (!done) begin
            if (re) begin
              state_d  = S_SET_R;
              settle_d = '0;
            end else if (se && have_ref_q) begin
              state_d  = S_SET_S;
              settle_d = '0;
            end
          end
        end
        S_SET_R, S_SET_S: begin
          seq_set = (re | se) & ~done;
          if (settle_q == SETTLE_END) begin
            adc_start_d = 1'b1;
            tmo_d       = '0;
            state_d     = (state_q == S_SET_R) ? S_CONV_R : S_CONV_S;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        S_CONV_R, S_CONV_S: begin
          seq_set = (re | se) & ~done;
          if (adc_valid) begin
            state_d = S_WAIT;
            if (state_q == S_CONV_R) begin
              ref_d      = adc_data;
              have_ref_d = 1'b1;
            end else begin
              push       = 1'b1;
              have_ref_d = 1'b0;
            end
          end else if (tmo_q == TMO_END) begin
            tmo_set    = 1'b1;
            have_ref_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A dropped pixel still consumes its index so pix_last stays aligned to the frame.
    if (push) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      if (!pix_valid_q || accept) begin
        pix_valid_d = 1'b1;
        pix_data_d  = pix_calc;
        pix_last_d  = (pix_cnt_q == LAST_IDX);
      end else begin
        ovf_set = 1'b1;
      end
    end

    overflow_d    = (overflow_q & ~err_clr) | ovf_set;
    seq_err_d     = (seq_err_q & ~err_clr) | seq_set;
    timeout_err_d = (timeout_err_q & ~err_clr) | tmo_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q           <= '0;
      ph_prev_q      <= '0;
      state_q        <= S_IDLE;
      settle_q       <= '0;
      tmo_q          <= '0;
      pix_cnt_q      <= '0;
      have_ref_q     <= 1'b0;
      ref_q          <= '0;
      adc_start_q    <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      pix_last_q     <= 1'b0;
      frame_active_q <= 1'b0;
      overflow_q     <= 1'b0;
      seq_err_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      ph_q           <= ph_d;
      ph_prev_q      <= ph_prev_d;
      state_q        <= state_d;
      settle_q       <= settle_d;
      tmo_q          <= tmo_d;
      pix_cnt_q      <= pix_cnt_d;
      have_ref_q     <= have_ref_d;
      ref_q          <= ref_d;
      adc_start_q    <= adc_start_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      pix_last_q     <= pix_last_d;
      frame_active_q <= frame_active_d;
      overflow_q     <= overflow_d;
      seq_err_q      <= seq_err_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign pix_last     = pix_last_q;
  assign frame_active = frame_active_q;
  assign overflow     = overflow_q;
  assign seq_err      = seq_err_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// Bench for ccd_cds_sampler: drives phase sequences and an ADC, predicts each pixel
// from ref/sig arithmetic and checks the output stream plus flag behaviour.
module tb_ccd_cds_sampler;

  localparam int W      = 12;
  localparam int NPIX   = 8;
  localparam int SETTLE = 8;
  localparam int TMO    = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         phi_p = 1'b0;
  logic         phi_r = 1'b0;
  logic         phi_l1 = 1'b0;
  logic         adc_valid = 1'b0;
  logic [W-1:0] adc_data = '0;
  logic         pix_ready = 1'b0;
  logic         err_clr = 1'b0;
  logic         adc_start, pix_valid, pix_last, frame_active;
  logic         overflow, seq_err, timeout_err;
  logic [W-1:0] pix_data;

  int           checks = 0;
  int           errors = 0;
  int           start_cnt = 0;
  int           model_cnt = 0;
  int           ready_mode = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];

  ccd_cds_sampler #(
    .ADC_W(W), .PIXELS(NPIX), .SETTLE_CYC(SETTLE), .ADC_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .phi_p(phi_p), .phi_r(phi_r), .phi_l1(phi_l1),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .frame_active(frame_active), .err_clr(err_clr),
    .overflow(overflow), .seq_err(seq_err), .timeout_err(timeout_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // consumer: ready changes mid-cycle, well away from both clock edges
  initial forever begin
    @(posedge clk);
    #2;
    pix_ready = (ready_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (adc_start) start_cnt++;
  end

  // scoreboard compare: every transfer against the model, every stall for stability
  initial begin
    logic         hold_prev;
    logic [W-1:0] hold_data;
    logic         hold_last;
    logic [W-1:0] e;
    logic         el;
    hold_prev = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_prev && pix_valid) begin
        check("hold_data", pix_data, hold_data);
        check("hold_last", pix_last, hold_last);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel actual=%0d expected=none", pix_data);
        end else begin
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("pix_data", pix_data, e);
          check("pix_last", pix_last, el);
        end
      end
      hold_prev = pix_valid && !pix_ready;
      hold_data = pix_data;
      hold_last = pix_last;
    end
  end

  // behavioural model: pixel = max(ref - sig, 0); last = index PIXELS-1
  function automatic void model_push(input logic [W-1:0] r, input logic [W-1:0] s, input bit drop);
    int           d;
    logic [W-1:0] v;
    d = int'(r) - int'(s);
    v = (d < 0) ? '0 : W'(d);
    if (!drop) begin
      exp_q.push_back(v);
      exp_last_q.push_back(model_cnt == NPIX - 1);
    end
    model_cnt++;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (!adc_start && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_latency"}, n, SETTLE + 2);
  endtask

  task automatic conv(input logic [W-1:0] val, input string tag, input bit do_push,
                      input logic [W-1:0] r, input bit drop);
    int n;
    wait_start(tag, n);
    if (!adc_start) return;
    if (do_push) model_push(r, val, drop);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    adc_data  = val;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    adc_data  = W'($urandom);
  endtask

  task automatic do_pixel(input logic [W-1:0] r, input logic [W-1:0] s, input bit drop);
    phi_r = 1'b1; tick(1); phi_r = 1'b0;
    conv(r, "ref", 1'b0, r, 1'b0);
    phi_l1 = 1'b0; tick(1); phi_l1 = 1'b1;
    conv(s, "sig", 1'b1, r, drop);
  endtask

  task automatic frame_start();
    phi_p = 1'b1; tick(2); phi_p = 1'b0; tick(3);
    model_cnt = 0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pix_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, int'(exp_q.size()) + int'(pix_valid), 0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_start"}, adc_start, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_last"}, pix_last, 0);
    check({tag, "_frame_active"}, frame_active, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // stimulus
  initial begin
    int           s0;
    int           n;
    logic [W-1:0] rv, sv;

    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1; enable = 1'b1; tick(2);

    // frame 1: first phi_l1 rise ignored, then a full frame
    frame_start();
    check("fs_frame_active", frame_active, 1);
    s0 = start_cnt;
    phi_l1 = 1'b1; tick(SETTLE + 6);
    check("first_se_no_start", start_cnt - s0, 0);
    check("first_se_no_seq_err", seq_err, 0);
    for (int i = 0; i < NPIX; i++) begin
      case (i)
        0: begin rv = 12'd500;  sv = 12'd900;  end
        1: begin rv = 12'd4095; sv = 12'd0;    end
        2: begin rv = 12'd3000; sv = 12'd1000; end
        3: begin rv = W'($urandom); sv = rv; end
        default: begin rv = W'($urandom); sv = W'($urandom); end
      endcase
      do_pixel(rv, sv, 1'b0);
    end
    wait_drain("frame1");
    check("frame1_active_low", frame_active, 0);
    check("frame1_overflow", overflow, 0);
    check("frame1_seq_err", seq_err, 0);
    check("frame1_timeout", timeout_err, 0);
    s0 = start_cnt;
    phi_r = 1'b1; tick(1); phi_r = 1'b0;
    phi_l1 = 1'b0; tick(1); phi_l1 = 1'b1; tick(SETTLE + 6);
    check("post_frame_no_start", start_cnt - s0, 0);
    check("post_frame_no_seq_err", seq_err, 0);

    // frame 2: overflow with stalled consumer
    frame_start();
    ready_mode = 1; tick(2);
    do_pixel(12'd3000, 12'd1000, 1'b0);
    do_pixel(12'd1234, 12'd234, 1'b1);
    tick(2);
    check("ovf_set", overflow, 1);
    check("ovf_hold_valid", pix_valid, 1);
    check("ovf_hold_data", pix_data, 2000);
    pulse_err_clr();
    check("ovf_cleared", overflow, 0);
    ready_mode = 0;
    wait_drain("ovf");

    // ADC timeout on a reference conversion
    phi_r = 1'b1; tick(1); phi_r = 1'b0;
    wait_start("tmo", n);
    n = 0;
    while (!timeout_err && n < 400) begin
      tick(1);
      n++;
    end
    check("timeout_latency", n, TMO);
    check("timeout_no_pixel", pix_valid, 0);
    s0 = start_cnt;
    phi_l1 = 1'b0; tick(1); phi_l1 = 1'b1; tick(SETTLE + 6);
    check("after_timeout_se_no_start", start_cnt - s0, 0);
    do_pixel(12'd2500, 12'd2400, 1'b0);
    wait_drain("after_timeout");
    pulse_err_clr();
    check("timeout_cleared", timeout_err, 0);

    // phi_r fall while the signal conversion is pending
    check("seq_err_before", seq_err, 0);
    phi_r = 1'b1; tick(1); phi_r = 1'b0;
    conv(12'd1800, "seq_ref", 1'b0, 12'd0, 1'b0);
    phi_l1 = 1'b0; tick(1); phi_l1 = 1'b1;
    wait_start("seq_sig", n);
    model_push(12'd1800, 12'd300, 1'b0);
    s0 = start_cnt;
    phi_r = 1'b1; tick(1); phi_r = 1'b0; tick(4);
    adc_data = 12'd300; adc_valid = 1'b1; tick(1); adc_valid = 1'b0;
    check("seq_err_set", seq_err, 1);
    wait_drain("seq");
    check("seq_no_extra_start", start_cnt - s0, 0);
    pulse_err_clr();
    check("seq_err_cleared", seq_err, 0);

    // asynchronous reset mid-conversion with a pixel buffered
    ready_mode = 1; tick(2);
    do_pixel(12'd1000, 12'd400, 1'b0);
    tick(2);
    check("buffered_before_reset", pix_valid, 1);
    phi_r = 1'b1; tick(1); phi_r = 1'b0;
    wait_start("rst", n);
    tick(2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    void'(exp_q.pop_back());
    void'(exp_last_q.pop_back());
    tick(2);
    rst_n = 1'b1;
    ready_mode = 0;
    s0 = start_cnt;
    phi_r = 1'b1; tick(1); phi_r = 1'b0;
    phi_l1 = 1'b0; tick(1); phi_l1 = 1'b1; tick(SETTLE + 6);
    check("no_start_before_fs", start_cnt - s0, 0);
    check("no_frame_before_fs", frame_active, 0);
    frame_start();
    do_pixel(12'd3000, 12'd1000, 1'b0);
    wait_drain("after_reset");
    check("final_overflow", overflow, 0);
    check("final_seq_err", seq_err, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccd_cds_sampler.md
# ccd_cds_sampler

Correlated-double-sampling controller that sits directly downstream of `digital_cs`, the CCD clock generator. It watches the generated phase lines (`phi_p`, `phi_r`, `phi_l1`) and triggers the external ADC twice per pixel: once for the reset (reference) level and once for the signal level. It subtracts the two samples and emits one clamped pixel word per pixel over a valid/ready stream with a line-end marker. All phase inputs are synchronous to `clk`.

## Interface

**Parameters**
- `ADC_W`, default 12: ADC sample width; also the pixel width.
- `PIXELS`, default 2051: number of paired pixels per frame. The clock generator's 2052 transfers yield 2051 reset/signal pairs.
- `SETTLE_CYC`, default 8: clock cycles between a qualifying phase edge and `adc_start`. Range 1..255.
- `ADC_TIMEOUT`, default 255: maximum cycles from `adc_start` to `adc_valid`. Range 1..1023.

**Ports**
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enable`, input, 1: same enable that drives the clock generator. Low forces IDLE.
- `phi_p`, input, 1: frame/parallel-transfer phase.
- `phi_r`, input, 1: reset-gate phase.
- `phi_l1`, input, 1: last horizontal phase; its rising edge dumps charge to the sense node.
- `adc_start`, output, 1: one-cycle conversion request.
- `adc_valid`, input, 1: one-cycle strobe qualifying `adc_data`.
- `adc_data`, input, `ADC_W`: conversion result.
- `pix_data`, output, `ADC_W`: CDS pixel value.
- `pix_valid`, output, 1: pixel available.
- `pix_ready`, input, 1: consumer accepts when high together with `pix_valid`.
- `pix_last`, output, 1: qualifies the final pixel of a frame.
- `frame_active`, output, 1: high between the frame start and acceptance of the last pixel.
- `err_clr`, input, 1: synchronous clear of the sticky error flags.
- `overflow`, output, 1: sticky flag; a pixel was dropped because the output buffer was full.
- `seq_err`, output, 1: sticky flag; a phase edge arrived outside the WAIT state.
- `timeout_err`, output, 1: sticky flag; `adc_valid` did not arrive within `ADC_TIMEOUT` cycles.

## Operation

**Edge detection**
- Phase inputs are registered once. Edges are derived from the current vs. previous registered value.
- Events: `fs` = falling edge of `phi_p`; `re` = falling edge of `phi_r`; `se` = rising edge of `phi_l1`.

**Frame start (`fs`)**
- Pixel counter ← 0, `have_ref` ← 0, `frame_active` ← 1.
- The FSM is forced to WAIT, which aborts any conversion in flight.

**FSM states**
- IDLE: entered whenever `enable` = 0. `have_ref` is cleared. Leaves only on `fs` while `enable` = 1.
- WAIT:
  - On `re` → SETTLE_R.
  - On `se` with `have_ref` = 1 → SETTLE_S.
  - On `se` with `have_ref` = 0: the event is ignored. This is the first transfer of a frame and is not an error.
- SETTLE_R / SETTLE_S: count `SETTLE_CYC` cycles, then pulse `adc_start` and go to CONV_R / CONV_S.
- CONV_R: on `adc_valid`, ref ← `adc_data`, `have_ref` ← 1, → WAIT.
- CONV_S: on `adc_valid`, compute the pixel and push it to the output buffer, `have_ref` ← 0, → WAIT.
- Timeout: in either CONV state, if `ADC_TIMEOUT` cycles elapse without `adc_valid`, set `timeout_err`, clear `have_ref`, → WAIT, and emit no pixel.

**Arithmetic**
- pix = ref − sig, computed at `ADC_W`+1 bits signed.
- If the result is negative, output 0. Otherwise output the low `ADC_W` bits.

**Output buffer**
- One entry. Push when empty, or when full and accepted in the same cycle.
- Push when full and not accepted: drop the new pixel, set `overflow`, and still increment the pixel counter.
- `pix_last` = 1 for the pixel whose index equals `PIXELS`−1. On acceptance of that pixel, `frame_active` ← 0.
- Once the counter reaches `PIXELS`, further `se`/`re` events are ignored without error until the next `fs`.

**Errors**
- `re` or `se` seen in SETTLE_* or CONV_* sets `seq_err`; the event is otherwise ignored.
- `fs` takes priority over every other event in the same cycle.
- `err_clr` clears all sticky flags. A set event in the same cycle wins.

## Timing

- Reset values: `adc_start`=0, `pix_valid`=0, `pix_data`=0, `pix_last`=0, `frame_active`=0, `overflow`=0, `seq_err`=0, `timeout_err`=0. FSM = IDLE, counter = 0, `have_ref`=0.
- `re`/`se` is detected 2 cycles after the raw input edge: input register plus edge compare.
- `adc_start` is asserted exactly `SETTLE_CYC` cycles after the FSM enters SETTLE_*.
- `pix_valid` rises the cycle after the CONV_S `adc_valid`. `pix_data` and `pix_last` are held stable while `pix_valid`=1 and `pix_ready`=0.
- `enable` falling mid-conversion: IDLE on the next cycle. A buffered pixel remains valid until accepted.
- `rst_n` low mid-operation: immediate asynchronous return to reset values, including the buffered pixel.

## Test plan

- Full frame, ADC model returning ref=3000 and sig=1000, `pix_ready`=1 → exactly 2051 pixels of value 2000, `pix_last` only on the 2051st, `frame_active` falls after it.
- First `phi_l1` rise after `fs` with no prior reset sample → no `adc_start`, `seq_err`=0. The first `adc_start` occurs `SETTLE_CYC`+2 cycles after the first `phi_r` fall.
- ref=500, sig=900 → pix_data=0. ref=4095, sig=0 → pix_data=4095.
- `pix_ready` held 0 across two pixels → the first is held stable, the second is dropped, `overflow`=1. `err_clr` → `overflow`=0.
- `adc_valid` withheld → `timeout_err`=1 after 255 cycles, no pixel emitted, and the next `re` is processed normally.
- `phi_r` fall during CONV_S → `seq_err`=1. `rst_n` pulsed mid-CONV → all outputs return to reset values and `adc_start` stays 0 until the next `fs`.
